// File: rtl/exec_seq.sv
// rtl/exec_seq.sv - address/control sequencer for one fully-connected pass
//
// Issues one source-buffer read per cycle and tags each term with its output
// address, marking the first term of each output (accr) and the last (outr).
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   start               one-cycle pass request, ignored unless idle
//   src_bank, dst_bank  bank selects, latched at start
//   acc                 accumulate onto existing partial sums, latched at start
//   in_len, out_len     terms per output - 1, outputs - 1, latched at start
//   stall               (EXEC_SEQ_STALL_EN only) hold issue while high in RUN
//   busy, done          pass in progress / one-cycle completion pulse
//   exec, ia            source read enable and address {src_bank, i}
//   outr, accr, oa      write-back tag, partial-sum read tag, {dst_bank, o}
//
// Optional feature macro: EXEC_SEQ_STALL_EN (adds the stall input).

module exec_seq #(
  parameter int DRAIN_CYC = 5,
  parameter int LW        = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          src_bank,
  input  logic          dst_bank,
  input  logic          acc,
  input  logic [LW-1:0] in_len,
  input  logic [LW-1:0] out_len,
`ifdef EXEC_SEQ_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic          exec,
  output logic [LW:0]   ia,
  output logic          outr,
  output logic          accr,
  output logic [LW:0]   oa
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_n;

  // i/o hold the term currently on the bus while exec=1, and the term still
  // waiting to be issued while a stall gap is on the bus.
  logic [LW-1:0] i_q, i_n;
  logic [LW-1:0] o_q, o_n;
  logic [LW-1:0] in_len_q, in_len_n;
  logic [LW-1:0] out_len_q, out_len_n;
  logic          src_q, src_n;
  logic          dst_q, dst_n;
  logic          acc_q, acc_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic          busy_n, done_n, exec_n, outr_n, accr_n;
  logic [LW:0]   ia_n, oa_n;

  logic [LW-1:0] ni, no;
  logic          last;
  logic          stall_w;

`ifdef EXEC_SEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    i_n       = i_q;
    o_n       = o_q;
    in_len_n  = in_len_q;
    out_len_n = out_len_q;
    src_n     = src_q;
    dst_n     = dst_q;
    acc_n     = acc_q;
    cnt_n     = cnt_q;
    busy_n    = busy;
    done_n    = 1'b0;
    exec_n    = 1'b0;
    outr_n    = 1'b0;
    accr_n    = 1'b0;
    ia_n      = ia;
    oa_n      = oa;
    ni        = i_q;
    no        = o_q;
    last      = (i_q == in_len_q) && (o_q == out_len_q);

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          // The first term goes straight onto the bus, so it is built from
          // the live inputs that are being latched this same cycle.
          state_n   = S_RUN;
          in_len_n  = in_len;
          out_len_n = out_len;
          src_n     = src_bank;
          dst_n     = dst_bank;
          acc_n     = acc;
          i_n       = '0;
          o_n       = '0;
          busy_n    = 1'b1;
          exec_n    = 1'b1;
          ia_n      = {src_bank, {LW{1'b0}}};
          oa_n      = {dst_bank, {LW{1'b0}}};
          accr_n    = acc;
          outr_n    = (in_len == '0);
        end
      end

      S_RUN: begin
        busy_n = 1'b1;
        if (exec && last) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          // Advance only past a term that actually issued; after a gap the
          // pending term is still the one held in i/o.
          if (exec) begin
            if (i_q == in_len_q) begin
              ni = '0;
              no = o_q + 1'b1;
            end else begin
              ni = i_q + 1'b1;
            end
          end
          i_n = ni;
          o_n = no;
          if (!stall_w) begin
            exec_n = 1'b1;
            ia_n   = {src_q, ni};
            oa_n   = {dst_q, no};
            accr_n = acc_q && (ni == '0);
            outr_n = (ni == in_len_q);
          end
        end
      end

      S_DRAIN: begin
        busy_n = 1'b1;
        if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      i_q       <= '0;
      o_q       <= '0;
      in_len_q  <= '0;
      out_len_q <= '0;
      src_q     <= 1'b0;
      dst_q     <= 1'b0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      exec      <= 1'b0;
      outr      <= 1'b0;
      accr      <= 1'b0;
      ia        <= '0;
      oa        <= '0;
    end else begin
      state     <= state_n;
      i_q       <= i_n;
      o_q       <= o_n;
      in_len_q  <= in_len_n;
      out_len_q <= out_len_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      exec      <= exec_n;
      outr      <= outr_n;
      accr      <= accr_n;
      ia        <= ia_n;
      oa        <= oa_n;
    end
  end

endmodule
